// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the unified memory port.
// The arbiter takes the slave modport; the requesters/RAM model take master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic        d_req;
  logic        d_we;
  logic [31:0] ram_rdata;
  logic        addr_sel;
  logic        ram_we;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  modport slave (
    input  if_req, d_req, d_we, ram_rdata,
    output addr_sel, ram_we, if_ready, if_rdata, d_ready, d_rdata
  );

  modport master (
    output if_req, d_req, d_we, ram_rdata,
    input  addr_sel, ram_we, if_ready, if_rdata, d_ready, d_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, data first,
// with a streak counter that forces a fetch grant after two back-to-back data wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t      r_state, w_state_nxt;
  logic        r_gnt, w_gnt_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_streak, w_streak_nxt;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        r_if_ready, r_d_ready;
  logic        w_if_ready_nxt, w_d_ready_nxt;
  logic        w_cap;
  logic        w_addr_sel, w_ram_we;
  logic        w_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_streak   <= w_streak_nxt;
      r_if_ready <= w_if_ready_nxt;
      r_d_ready  <= w_d_ready_nxt;
      if (w_cap && !r_gnt) r_if_rdata <= bus.ram_rdata;
      if (w_cap &&  r_gnt) r_d_rdata  <= bus.ram_rdata;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_cnt_nxt      = r_cnt;
    w_streak_nxt   = r_streak;
    w_if_ready_nxt = 1'b0;
    w_d_ready_nxt  = 1'b0;
    w_cap          = 1'b0;
    w_addr_sel     = 1'b0;
    w_ram_we       = 1'b0;
    // Data wins a tie unless fetch has already lost twice in a row.
    w_grant_d      = bus.d_req && !(bus.if_req && (r_streak == 2'd2));
    case (r_state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'd1;
          w_gnt_nxt   = w_grant_d;
          if (w_grant_d && bus.if_req)
            w_streak_nxt = (r_streak == 2'd2) ? 2'd2 : r_streak + 2'd1;
          else
            w_streak_nxt = 2'd0;
        end
      end
      BUSY: begin
        w_addr_sel = r_gnt;
        w_ram_we   = (r_cnt == 4'd1) && r_gnt && bus.d_we;
        if (r_cnt == LAT) begin
          w_cap          = 1'b1;
          w_state_nxt    = DONE;
          w_if_ready_nxt = !r_gnt;
          w_d_ready_nxt  = r_gnt;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_addr_sel  = r_gnt;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.addr_sel = w_addr_sel;
  assign bus.ram_we   = w_ram_we;
  assign bus.if_ready = r_if_ready;
  assign bus.d_ready  = r_d_ready;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (latency 2 and 1) in lockstep and compares every cycle
// against a transaction-level model: grant time t0, outputs are a function of cycle - t0.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if b2();
  mem_port_arbiter_if b1();

  mem_port_arbiter #(.MEM_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic        ir [2];
  logic        dr [2];
  logic        we [2];
  logic [31:0] rd [2];

  assign b2.if_req = ir[0];  assign b1.if_req = ir[1];
  assign b2.d_req  = dr[0];  assign b1.d_req  = dr[1];
  assign b2.d_we   = we[0];  assign b1.d_we   = we[1];
  assign b2.ram_rdata = rd[0]; assign b1.ram_rdata = rd[1];

  logic        o_as [2], o_we [2], o_irdy [2], o_drdy [2];
  logic [31:0] o_ird [2], o_drd [2];
  assign o_as[0] = b2.addr_sel;   assign o_as[1] = b1.addr_sel;
  assign o_we[0] = b2.ram_we;     assign o_we[1] = b1.ram_we;
  assign o_irdy[0] = b2.if_ready; assign o_irdy[1] = b1.if_ready;
  assign o_drdy[0] = b2.d_ready;  assign o_drdy[1] = b1.d_ready;
  assign o_ird[0] = b2.if_rdata;  assign o_ird[1] = b1.if_rdata;
  assign o_drd[0] = b2.d_rdata;   assign o_drd[1] = b1.d_rdata;

  // Reference model state
  int          lat [2] = '{2, 1};
  bit          act [2];
  int          t0 [2];
  bit          mg [2], mwe [2];
  int          streak [2];
  logic [31:0] mird [2], mdrd [2];
  bit          glog [$];
  int          cyc;
  logic        s_ir [2], s_dr [2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int k;
    bit gd;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      k = act[d] ? (cyc - t0[d]) : 0;
      s_ir[d] = o_irdy[d];
      s_dr[d] = o_drdy[d];
      chk($sformatf("addr_sel%0d", d), o_as[d],   act[d] && k >= 1 && mg[d]);
      chk($sformatf("ram_we%0d", d),   o_we[d],   act[d] && k == 1 && mg[d] && mwe[d]);
      chk($sformatf("if_ready%0d", d), o_irdy[d], act[d] && k == lat[d] + 1 && !mg[d]);
      chk($sformatf("d_ready%0d", d),  o_drdy[d], act[d] && k == lat[d] + 1 && mg[d]);
      chk($sformatf("if_rdata%0d", d), o_ird[d],  mird[d]);
      chk($sformatf("d_rdata%0d", d),  o_drd[d],  mdrd[d]);
      if (act[d]) begin
        if (k == lat[d]) begin
          if (mg[d]) mdrd[d] = rd[d];
          else       mird[d] = rd[d];
        end
        if (k == lat[d] + 1) act[d] = 1'b0;
      end else if (!rst && (ir[d] || dr[d])) begin
        gd = dr[d] && !(ir[d] && streak[d] == 2);
        mg[d] = gd;
        mwe[d] = we[d];
        if (gd && ir[d]) streak[d] = (streak[d] >= 2) ? 2 : streak[d] + 1;
        else             streak[d] = 0;
        act[d] = 1'b1;
        t0[d] = cyc;
        if (d == 0) glog.push_back(gd);
      end
      if (rst) begin
        act[d] = 1'b0; streak[d] = 0; mird[d] = '0; mdrd[d] = '0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold each request until its ready pulse, then drop it.
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (s_ir[d]) ir[d] = 1'b0;
        if (s_dr[d]) dr[d] = 1'b0;
      end
    end
  endtask

  task automatic set_all(input logic i_v, input logic d_v, input logic w_v, input logic [31:0] r_v);
    for (int d = 0; d < 2; d++) begin
      ir[d] = i_v; dr[d] = d_v; we[d] = w_v; rd[d] = r_v;
    end
  endtask

  logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    cyc = 0;
    set_all(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    step();

    set_all(1'b1, 1'b0, 1'b0, 32'h8C010004);
    serve(6);
    chk("fetch_word", o_ird[0], 32'h8C010004);
    chk("fetch_no_dready", {31'b0, o_drdy[0]}, 32'h0);

    set_all(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    serve(6);

    set_all(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5);
    serve(12);

    step();
    glog.delete();
    set_all(1'b1, 1'b1, 1'b0, 32'h0BADF00D);
    for (int i = 0; i < 26; i++) begin
      rd[0] = $urandom; rd[1] = $urandom;
      step();
    end
    chk("starve_count_ok", {31'b0, glog.size() >= 6}, 32'h1);
    if (glog.size() >= 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("starve_seq%0d", i), {31'b0, glog[i]}, {31'b0, pat[i]});
    serve(16);

    step();
    set_all(1'b0, 1'b1, 1'b0, 32'h77777777);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_abort_drdata", o_drd[0], 32'h0);
    serve(8);

    set_all(1'b0, 1'b1, 1'b0, 32'h12345678);
    serve(5);
    chk("lat1_rdata", o_drd[1], 32'h12345678);

    for (int i = 0; i < 1500; i++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        rd[d] = $urandom;
        if (ir[d]) begin
          if (s_ir[d]) ir[d] = $urandom_range(0, 1) == 1;
        end else begin
          ir[d] = $urandom_range(0, 2) == 0;
        end
        if (dr[d]) begin
          if (s_dr[d]) begin
            dr[d] = $urandom_range(0, 1) == 1;
            we[d] = $urandom_range(0, 1) == 1;
          end
        end else begin
          dr[d] = $urandom_range(0, 2) == 0;
          we[d] = $urandom_range(0, 1) == 1;
        end
      end
    end
    rst = 1'b0;
    serve(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU. It drives the select of the external 32-bit 2:1 address/data mux in front of the RAM and issues the RAM write strobe. It counts out the fixed RAM latency, captures read data and returns a one-cycle ready pulse to the granted requester. Data accesses have priority, and an anti-starvation rule guarantees fetch progress.

## Interface
- MEM_LATENCY, 2, RAM read latency in cycles from address valid to ram_rdata valid; legal range 1..15
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until if_ready
- d_req  in  1  data request; level, held until d_ready
- d_we  in  1  data request is a write; stable while d_req high
- ram_rdata  in  32  RAM read data
- addr_sel  out  1  select of external address/wdata mux: 0 = IF address, 1 = MEM address/wdata
- ram_we  out  1  RAM write enable
- if_ready  out  1  one-cycle completion pulse for fetch
- if_rdata  out  32  captured instruction word
- d_ready  out  1  one-cycle completion pulse for data access
- d_rdata  out  32  captured load data (undefined content for writes, still updated)

## Operation
- States: IDLE, BUSY, DONE. Registers: state, gnt (0 = IF, 1 = data), 4-bit cnt, 2-bit streak, if_rdata, d_rdata.
- IDLE, no request: stay; all strobes 0.
- IDLE with a request: enter BUSY and set cnt = 1.
  - Grant decision: if only one request is high, grant it.
  - If both are high, grant data unless streak == 2, in which case grant fetch.
- Streak update at each grant:
  - Fetch grant: streak = 0.
  - Data grant with if_req = 1: streak = streak + 1 (saturates at 2).
  - Data grant with if_req = 0: streak = 0.
- BUSY: addr_sel = gnt.
  - ram_we = 1 only when cnt == 1, gnt = 1 and d_we = 1.
  - When cnt == MEM_LATENCY: capture ram_rdata into if_rdata (gnt = 0) or d_rdata (gnt = 1), then go to DONE. Otherwise increment cnt.
- DONE: pulse if_ready or d_ready per gnt, addr_sel holds gnt, then go to IDLE.
- Requesters hold address/wdata stable while req is high. A req still high in the cycle after its ready pulse is a new request.
- Requests arriving during BUSY/DONE wait. No preemption.
- if_rdata/d_rdata hold their value until the next capture for the same requester.

## Timing
- Request seen in IDLE at cycle 0.
- BUSY spans cycles 1..MEM_LATENCY; capture at the end of cycle MEM_LATENCY.
- Ready pulse in cycle MEM_LATENCY+1; IDLE in cycle MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles (one bubble IDLE cycle between accesses).
- ram_we is high for exactly one cycle (cycle 1) per write and is never high outside BUSY.
- ready outputs are registered and never high for two consecutive cycles.
- Reset values: state IDLE, gnt 0, cnt 0, streak 0, addr_sel 0, ram_we 0, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0.
- rst mid-access (BUSY or DONE): next cycle is IDLE with all outputs at reset values. The aborted access produces no ready pulse. rst overrides all requests.
- Reset with MEM_LATENCY = 1: BUSY lasts one cycle; the cnt == 1 write strobe and the capture happen in the same cycle.

## Test plan
- Fetch alone, MEM_LATENCY = 2: if_req = 1 at cycle 0; ram_rdata = 0x8C010004 in cycle 2 -> addr_sel = 0 in cycles 1–3, if_ready = 1 only in cycle 3, if_rdata = 0x8C010004; d_ready stays 0.
- Data write: d_req = 1, d_we = 1 at cycle 0 -> addr_sel = 1 in cycles 1–3, ram_we = 1 only in cycle 1, d_ready = 1 in cycle 3.
- Simultaneous requests at cycle 0 -> data served first (d_ready cycle 3); fetch granted in IDLE cycle 4, if_ready in cycle 7.
- Starvation: d_req and if_req both continuously high (re-requesting after every ready) -> grant sequence D, D, I, D, D, I. Streak returns to 0 after each I.
- Reset mid-access: data read granted at cycle 0, rst = 1 in cycle 1 -> cycle 2 state IDLE, no d_ready, ram_we 0, d_rdata 0. The next request after rst drops is served normally.
- MEM_LATENCY = 1 read: d_req at cycle 0, ram_rdata = 0x12345678 in cycle 1 -> d_ready in cycle 2 with d_rdata = 0x12345678.
